// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type and priority-mode constants for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_LOAD, ARB_STORE} arb_state_t;
    localparam int PRIO_RR = 0;
    localparam int PRIO_FIXED = 1;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational winner selection, round-robin from rr_ptr or fixed lowest-index
module rr_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PRIO_MODE = PRIO_RR,
    parameter int SEL_W = $clog2(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] pending,
    input  logic [SEL_W-1:0]   rr_ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               any_valid
);
    // scan offsets from farthest to nearest so the first pending index at or after the start wins
    always_comb begin
        int base;
        int pos;
        logic [SEL_W-1:0] idx;
        base = PRIO_MODE == PRIO_FIXED ? 0 : int'(rr_ptr);
        pos = 0;
        idx = '0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = base + k >= NUM_REQ ? base + k - NUM_REQ : base + k;
            idx = SEL_W'(pos);
            winner = pending[idx] ? idx : winner;
        end
        any_valid = |pending;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates NUM_REQ load/store requesters onto one memory port with timeout
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int SEL_W = $clog2(NUM_REQ),
    parameter int PRIO_MODE = PRIO_RR,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] load_req_in,
    input  logic [NUM_REQ-1:0] store_req_in,
    input  logic               mem_output_valid_in,
    input  logic               mem_write_ready_in,
    output logic [SEL_W-1:0]   addr_select_out,
    output logic               mem_read_en_out,
    output logic               mem_write_en_out,
    output logic [NUM_REQ-1:0] grant_out,
    output logic [NUM_REQ-1:0] stall_out,
    output logic               done_out,
    output logic               timeout_err_out
);
    localparam int CNT_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_REQ - 1);

    arb_state_t         state;
    logic [SEL_W-1:0]   owner;
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   winner;
    logic [CNT_W-1:0]   wait_cnt;
    logic               timeout_err;
    logic               any_valid;
    logic               completing;
    logic               timed_out;
    logic [NUM_REQ-1:0] pending;

    rr_priority_picker #(
        .NUM_REQ(NUM_REQ),
        .PRIO_MODE(PRIO_MODE),
        .SEL_W(SEL_W)
    ) u_picker (
        .pending(pending),
        .rr_ptr(rr_ptr),
        .winner(winner),
        .any_valid(any_valid)
    );

    // output decode: everything but stall/done comes straight from registers
    always_comb begin
        pending = load_req_in | store_req_in;
        completing = state == ARB_LOAD ? mem_output_valid_in : state == ARB_STORE ? mem_write_ready_in : 1'b0;
        timed_out = TIMEOUT_CYCLES != 0 && state != ARB_IDLE && wait_cnt == CNT_LAST;
        grant_out = state == ARB_IDLE ? '0 : NUM_REQ'(1) << owner;
        stall_out = pending & ~(grant_out & {NUM_REQ{completing}});
        done_out = completing;
        addr_select_out = owner;
        mem_read_en_out = state == ARB_LOAD;
        mem_write_en_out = state == ARB_STORE;
        timeout_err_out = timeout_err;
    end

    // transaction FSM: grant from IDLE, finish on completion or timeout, then rest one IDLE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
            owner <= '0;
            rr_ptr <= '0;
            wait_cnt <= '0;
            timeout_err <= 1'b0;
        end else if (state == ARB_IDLE) begin
            timeout_err <= 1'b0;
            wait_cnt <= '0;
            if (any_valid) begin
                owner <= winner;
                state <= load_req_in[winner] ? ARB_LOAD : ARB_STORE;
            end
        end else if (completing || timed_out) begin
            state <= ARB_IDLE;
            timeout_err <= ~completing;
            if (PRIO_MODE == PRIO_RR) rr_ptr <= owner == SEL_LAST ? '0 : owner + 1'b1;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] ld = '0;
    logic [3:0] st = '0;
    logic [2:0] ld3 = '0;
    logic vld = 1'b0;
    logic rdy = 1'b0;
    logic [1:0] addr [2];
    logic [3:0] gnt [2];
    logic [3:0] stl [2];
    logic rd [2];
    logic wr [2];
    logic dn [2];
    logic er [2];
    logic [1:0] a3;
    logic [2:0] g3, s3;
    logic rd3, wr3, d3, e3;
    int checks = 0;
    int errors = 0;
    int m_busy [2], m_load [2], m_own [2], m_ptr [2], m_age [2], m_err [2];
    int m_mode [2] = '{0, 1};
    int m_tmo [2] = '{8, 0};

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(4), .PRIO_MODE(0), .TIMEOUT_CYCLES(8)) u0 (
        .clk(clk), .reset(reset), .load_req_in(ld), .store_req_in(st),
        .mem_output_valid_in(vld), .mem_write_ready_in(rdy),
        .addr_select_out(addr[0]), .mem_read_en_out(rd[0]), .mem_write_en_out(wr[0]),
        .grant_out(gnt[0]), .stall_out(stl[0]), .done_out(dn[0]), .timeout_err_out(er[0])
    );

    mem_port_arbiter #(.NUM_REQ(4), .PRIO_MODE(1), .TIMEOUT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .load_req_in(ld), .store_req_in(st),
        .mem_output_valid_in(vld), .mem_write_ready_in(rdy),
        .addr_select_out(addr[1]), .mem_read_en_out(rd[1]), .mem_write_en_out(wr[1]),
        .grant_out(gnt[1]), .stall_out(stl[1]), .done_out(dn[1]), .timeout_err_out(er[1])
    );

    mem_port_arbiter #(.NUM_REQ(3), .PRIO_MODE(0), .TIMEOUT_CYCLES(255)) u2 (
        .clk(clk), .reset(reset), .load_req_in(ld3), .store_req_in(3'b000),
        .mem_output_valid_in(vld), .mem_write_ready_in(rdy),
        .addr_select_out(a3), .mem_read_en_out(rd3), .mem_write_en_out(wr3),
        .grant_out(g3), .stall_out(s3), .done_out(d3), .timeout_err_out(e3)
    );

    task automatic reset_all;
        @(negedge clk);
        reset = 1'b1;
        ld = '0; st = '0; ld3 = '0; vld = 1'b0; rdy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 2; j++) begin
            m_busy[j] = 0; m_load[j] = 0; m_own[j] = 0; m_ptr[j] = 0; m_age[j] = 0; m_err[j] = 0;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        ld = 4'b0101;
        @(negedge clk); #1;
        checks++;
        if ({gnt[0], addr[0], rd[0], wr[0], dn[0], er[0]} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {gnt[0], addr[0], rd[0], wr[0], dn[0], er[0]});
        end
        checks++;
        if (stl[0] !== 4'b0101) begin errors++; $display("FAIL reset_stall: got %b expected 0101", stl[0]); end
        checks++;
        if (g3 !== 3'b000) begin errors++; $display("FAIL reset_grant3: got %b expected 000", g3); end
        reset = 1'b0;
        ld = '0;
    endtask

    task automatic test_alternate;
        reset_all;
        ld = 4'b0011;
        for (int t = 0; t < 4; t++) begin
            int e;
            e = t % 2;
            @(negedge clk); #1;
            checks++;
            if (gnt[0] !== 4'(1 << e)) begin errors++; $display("FAIL alt_grant: got %b expected %b", gnt[0], 4'(1 << e)); end
            checks++;
            if (stl[0][1-e] !== 1'b1) begin errors++; $display("FAIL alt_stall: got %b expected other bit set", stl[0]); end
            @(negedge clk);
            @(negedge clk);
            vld = 1'b1; #1;
            checks++;
            if (dn[0] !== 1'b1 || stl[0][e] !== 1'b0) begin
                errors++; $display("FAIL alt_done: got done %b stall %b expected done 1 owner unstalled", dn[0], stl[0]);
            end
            @(negedge clk);
            vld = 1'b0; #1;
            checks++;
            if (gnt[0] !== 4'b0000) begin errors++; $display("FAIL alt_idle: got %b expected 0000", gnt[0]); end
        end
        ld = '0;
    endtask

    task automatic test_fixed;
        reset_all;
        ld = 4'b1010;
        @(negedge clk); #1;
        checks++;
        if (gnt[1] !== 4'b0010 || addr[1] !== 2'd1) begin
            errors++; $display("FAIL fixed_first: got grant %b addr %0d expected 0010 addr 1", gnt[1], addr[1]);
        end
        vld = 1'b1; #1;
        checks++;
        if (dn[1] !== 1'b1) begin errors++; $display("FAIL fixed_done: got %b expected 1", dn[1]); end
        @(negedge clk);
        vld = 1'b0;
        ld = 4'b1000;
        @(negedge clk); #1;
        checks++;
        if (gnt[1] !== 4'b1000 || addr[1] !== 2'd3) begin
            errors++; $display("FAIL fixed_second: got grant %b addr %0d expected 1000 addr 3", gnt[1], addr[1]);
        end
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        ld = '0;
    endtask

    task automatic test_load_store;
        reset_all;
        ld = 4'b0100;
        st = 4'b0100;
        @(negedge clk); #1;
        checks++;
        if (rd[0] !== 1'b1 || wr[0] !== 1'b0 || addr[0] !== 2'd2) begin
            errors++; $display("FAIL ls_load: got rd %b wr %b addr %0d expected 1 0 2", rd[0], wr[0], addr[0]);
        end
        vld = 1'b1; #1;
        checks++;
        if (dn[0] !== 1'b1) begin errors++; $display("FAIL ls_load_done: got %b expected 1", dn[0]); end
        @(negedge clk);
        vld = 1'b0;
        ld = '0;
        @(negedge clk); #1;
        checks++;
        if (rd[0] !== 1'b0 || wr[0] !== 1'b1 || addr[0] !== 2'd2) begin
            errors++; $display("FAIL ls_store: got rd %b wr %b addr %0d expected 0 1 2", rd[0], wr[0], addr[0]);
        end
        vld = 1'b1; #1;
        checks++;
        if (dn[0] !== 1'b0) begin errors++; $display("FAIL ls_ignore_valid: got %b expected 0", dn[0]); end
        @(negedge clk);
        vld = 1'b0;
        rdy = 1'b1; #1;
        checks++;
        if (wr[0] !== 1'b1 || dn[0] !== 1'b1) begin
            errors++; $display("FAIL ls_store_done: got wr %b done %b expected 1 1", wr[0], dn[0]);
        end
        @(negedge clk);
        rdy = 1'b0;
        st = '0; #1;
        checks++;
        if (gnt[0] !== 4'b0000 || er[0] !== 1'b0) begin
            errors++; $display("FAIL ls_idle: got grant %b err %b expected 0000 0", gnt[0], er[0]);
        end
    endtask

    task automatic test_timeout;
        reset_all;
        st = 4'b0011;
        @(negedge clk); #1;
        checks++;
        if (gnt[0] !== 4'b0001 || wr[0] !== 1'b1) begin
            errors++; $display("FAIL to_grant: got grant %b wr %b expected 0001 1", gnt[0], wr[0]);
        end
        for (int k = 1; k < 8; k++) begin
            @(negedge clk); #1;
            checks++;
            if (er[0] !== 1'b0 || gnt[0] !== 4'b0001) begin
                errors++; $display("FAIL to_wait%0d: got err %b grant %b expected 0 0001", k, er[0], gnt[0]);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (er[0] !== 1'b1 || gnt[0] !== 4'b0000 || dn[0] !== 1'b0) begin
            errors++; $display("FAIL to_abort: got err %b grant %b done %b expected 1 0000 0", er[0], gnt[0], dn[0]);
        end
        @(negedge clk); #1;
        checks++;
        if (er[0] !== 1'b0 || gnt[0] !== 4'b0010) begin
            errors++; $display("FAIL to_next: got err %b grant %b expected 0 0010", er[0], gnt[0]);
        end
        st = '0;
    endtask

    task automatic test_reset_mid;
        reset_all;
        ld = 4'b0100;
        @(negedge clk); #1;
        checks++;
        if (rd[0] !== 1'b1) begin errors++; $display("FAIL rm_load: got %b expected 1", rd[0]); end
        vld = 1'b1; #1;
        reset = 1'b1; #1;
        checks++;
        if ({gnt[0], addr[0], rd[0], wr[0], dn[0], er[0]} !== 10'd0 || stl[0] !== 4'b0100) begin
            errors++; $display("FAIL rm_async: got %b stall %b expected 0 stall 0100",
                {gnt[0], addr[0], rd[0], wr[0], dn[0], er[0]}, stl[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        vld = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (gnt[0] !== 4'b0100 || addr[0] !== 2'd2) begin
            errors++; $display("FAIL rm_regrant: got grant %b addr %0d expected 0100 2", gnt[0], addr[0]);
        end
        ld = '0;
    endtask

    task automatic test_wrap;
        reset_all;
        ld3 = 3'b100;
        @(negedge clk); #1;
        checks++;
        if (g3 !== 3'b100 || a3 !== 2'd2) begin errors++; $display("FAIL wrap_first: got %b addr %0d expected 100 2", g3, a3); end
        vld = 1'b1; #1;
        checks++;
        if (d3 !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b expected 1", d3); end
        @(negedge clk);
        vld = 1'b0;
        ld3 = 3'b101;
        @(negedge clk); #1;
        checks++;
        if (g3 !== 3'b001 || a3 !== 2'd0) begin errors++; $display("FAIL wrap_second: got %b addr %0d expected 001 0", g3, a3); end
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        ld3 = '0;
    endtask

    task automatic test_random;
        reset_all;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            ld = 4'($urandom_range(0, 15));
            st = 4'($urandom_range(0, 15));
            vld = $urandom_range(0, 3) == 0;
            rdy = $urandom_range(0, 3) == 0;
            #1;
            for (int j = 0; j < 2; j++) begin
                logic comp;
                logic [3:0] eg, es;
                comp = m_busy[j] != 0 && (m_load[j] != 0 ? vld : rdy);
                eg = m_busy[j] != 0 ? 4'(1 << m_own[j]) : 4'b0000;
                es = (ld | st) & ~(comp ? eg : 4'b0000);
                checks++;
                if (gnt[j] !== eg || addr[j] !== 2'(m_own[j])) begin
                    errors++; $display("FAIL rnd_grant u%0d cyc %0d: got %b/%0d expected %b/%0d", j, c, gnt[j], addr[j], eg, m_own[j]);
                end
                checks++;
                if (rd[j] !== (m_busy[j] != 0 && m_load[j] != 0) || wr[j] !== (m_busy[j] != 0 && m_load[j] == 0)) begin
                    errors++; $display("FAIL rnd_enable u%0d cyc %0d: got rd %b wr %b", j, c, rd[j], wr[j]);
                end
                checks++;
                if (dn[j] !== comp || er[j] !== (m_err[j] != 0)) begin
                    errors++; $display("FAIL rnd_pulse u%0d cyc %0d: got done %b err %b expected %b %0d", j, c, dn[j], er[j], comp, m_err[j]);
                end
                checks++;
                if (stl[j] !== es) begin errors++; $display("FAIL rnd_stall u%0d cyc %0d: got %b expected %b", j, c, stl[j], es); end
            end
            @(posedge clk);
            for (int j = 0; j < 2; j++) begin
                logic comp;
                int found;
                comp = m_busy[j] != 0 && (m_load[j] != 0 ? vld : rdy);
                m_err[j] = 0;
                if (m_busy[j] == 0) begin
                    found = 0;
                    for (int k = 0; k < 4; k++) begin
                        int idx;
                        idx = ((m_mode[j] == 1 ? 0 : m_ptr[j]) + k) % 4;
                        if (found == 0 && (ld[idx] | st[idx])) begin found = 1; m_own[j] = idx; end
                    end
                    if (found != 0) begin m_busy[j] = 1; m_load[j] = ld[m_own[j]] ? 1 : 0; m_age[j] = 0; end
                end else if (comp) begin
                    m_busy[j] = 0; m_ptr[j] = (m_own[j] + 1) % 4;
                end else if (m_tmo[j] != 0 && m_age[j] == m_tmo[j] - 1) begin
                    m_busy[j] = 0; m_err[j] = 1; m_ptr[j] = (m_own[j] + 1) % 4;
                end else begin
                    m_age[j]++;
                end
            end
        end
        ld = '0;
        st = '0;
        vld = 1'b0;
        rdy = 1'b0;
    endtask

    initial begin
        test_reset;
        test_alternate;
        test_fixed;
        test_load_store;
        test_timeout;
        test_reset_mid;
        test_wrap;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
